// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake between a producer (CPU/peripheral) and the UART transmitter FIFO.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Producer side: offers a byte, observes back-pressure.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side: accepts a byte when not full.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO. Bit timing is driven by an
// external oversampling tick enable in the clk domain; txd is registered.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TICKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        tick,
    uart_tx_fifo_if.slave               tx,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned STOP_TICKS = STOP_BITS * TICKS_PER_BIT;
    localparam int unsigned CW         = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_TICKS - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    state_t        state;
    logic [CW-1:0] tcnt;
    logic [2:0]    bidx;
    logic [7:0]    shift;

    assign tx.tx_ready = (fifo_level != LEVEL_MAX);

    // Handshake and dequeue decisions; pop looks only at the registered level.
    always_comb begin
        push = tx.tx_valid && tx.tx_ready;
        pop  = 1'b0;
        if (tick && (fifo_level != '0)) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if ((state == STOP) && (tcnt == STOP_LAST)) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.tx_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame sequencer: advances only on tick cycles and registers txd/busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
            tcnt  <= '0;
            bidx  <= '0;
            shift <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        txd   <= 1'b0;
                        tcnt  <= '0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (tcnt == BIT_LAST) begin
                        tcnt  <= '0;
                        bidx  <= '0;
                        txd   <= shift[0];
                        state <= DATA;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tcnt == BIT_LAST) begin
                        tcnt <= '0;
                        if (bidx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bidx <= bidx + 3'd1;
                            txd  <= shift[bidx + 3'd1];
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                STOP: begin
                    if (tcnt == STOP_LAST) begin
                        tcnt <= '0;
                        if (pop) begin
                            // Next start bit follows the stop period with no idle gap.
                            shift <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    tcnt  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: waveform table for one frame, multi-frame
// sequences, and a 4x-oversampling receiver model decoding txd.
module tb_uart_tx_fifo;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic tick   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus2 ();

    logic       txd, busy;
    logic [2:0] level;
    logic       txd2, busy2;
    logic [2:0] level2;

    uart_tx_fifo #(.FIFO_DEPTH(4), .TICKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .resetn(resetn), .tick(tick), .tx(bus.slave),
        .txd(txd), .busy(busy), .fifo_level(level)
    );

    uart_tx_fifo #(.FIFO_DEPTH(4), .TICKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .resetn(resetn), .tick(tick), .tx(bus2.slave),
        .txd(txd2), .busy(busy2), .fifo_level(level2)
    );

    int errors = 0;
    int checks = 0;

    // Receiver model: detects start on a tick sample, then samples mid-bit.
    logic       rx_busy   = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_sh     = '0;
    int         frame_err = 0;
    logic [7:0] rx_q [$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
            rx_sh   <= '0;
            rx_q.delete();
        end else if (tick) begin
            if (!rx_busy) begin
                if (txd == 1'b0) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
                    rx_sh <= {txd, rx_sh[7:1]};
                if (rx_cnt == 37) begin
                    rx_busy <= 1'b0;
                    if (txd) rx_q.push_back(rx_sh);
                    else frame_err <= frame_err + 1;
                end
            end
        end
    end

    // txd may only move on the edge of a tick cycle (reset excepted).
    logic tick_at_edge = 1'b0;
    logic txd_prev     = 1'b1;
    int   glitch       = 0;
    always @(posedge clk) tick_at_edge <= tick;
    always @(negedge clk) begin
        if (resetn && !tick_at_edge && (txd !== txd_prev)) glitch <= glitch + 1;
        txd_prev <= txd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_step(input bit tk);
        tick = tk;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        clk_step(1'b0);
        bus.tx_valid = 1'b0;
    endtask

    task automatic rx_expect(input string name, input logic [7:0] exp);
        logic [7:0] got;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        else got = 'x;
        check(name, {24'b0, got}, {24'b0, exp});
    endtask

    task automatic wait_idle(input string name, input int gap);
        int n = 0;
        while ((busy || level != 0) && n < 2000) begin
            clk_step(1'b1);
            repeat (gap) clk_step(1'b0);
            n++;
        end
        check(name, (n < 2000) ? 1 : 0, 1);
    endtask

    typedef struct {
        int         k;
        logic       txd;
        logic       busy;
        logic [2:0] level;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       hist_txd  [1:122];
        logic       hist_busy [1:122];
        logic       rb;
        logic [7:0] d;
        int         cnt, cyc, lows, first_high, end_k;
        bit         done;

        // Expected line after the k-th tick edge for a lone 0x55 (start at k=1).
        tbl[0]  = '{1,  1'b0, 1'b1, 3'd0};
        tbl[1]  = '{4,  1'b0, 1'b1, 3'd0};
        tbl[2]  = '{5,  1'b1, 1'b1, 3'd0};
        tbl[3]  = '{9,  1'b0, 1'b1, 3'd0};
        tbl[4]  = '{13, 1'b1, 1'b1, 3'd0};
        tbl[5]  = '{17, 1'b0, 1'b1, 3'd0};
        tbl[6]  = '{21, 1'b1, 1'b1, 3'd0};
        tbl[7]  = '{25, 1'b0, 1'b1, 3'd0};
        tbl[8]  = '{29, 1'b1, 1'b1, 3'd0};
        tbl[9]  = '{33, 1'b0, 1'b1, 3'd0};
        tbl[10] = '{36, 1'b0, 1'b1, 3'd0};
        tbl[11] = '{37, 1'b1, 1'b1, 3'd0};
        tbl[12] = '{40, 1'b1, 1'b1, 3'd0};
        tbl[13] = '{41, 1'b1, 1'b0, 3'd0};

        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus2.tx_valid = 1'b0;
        bus2.tx_data  = '0;

        // Reset state
        repeat (3) clk_step(1'b0);
        resetn = 1'b1;
        clk_step(1'b0);
        check("reset txd", txd, 1);
        check("reset busy", busy, 0);
        check("reset tx_ready", bus.tx_ready, 1);
        check("reset level", level, 0);

        // Single byte, tick every 10 clocks
        push(8'h55);
        check("single level after push", level, 1);
        begin
            int idx = 0;
            for (int k = 1; k <= 41; k++) begin
                clk_step(1'b1);
                if (idx < 14 && tbl[idx].k == k) begin
                    check($sformatf("single txd k=%0d", k), txd, tbl[idx].txd);
                    check($sformatf("single busy k=%0d", k), busy, tbl[idx].busy);
                    check($sformatf("single level k=%0d", k), level, tbl[idx].level);
                    idx++;
                end
                repeat (9) clk_step(1'b0);
            end
        end
        rx_expect("single rx byte", 8'h55);

        // Back-to-back frames
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h48; clk_step(1'b0);
        bus.tx_data = 8'h69; clk_step(1'b0);
        bus.tx_data = 8'h0A; clk_step(1'b0);
        bus.tx_valid = 1'b0;
        check("b2b level", level, 3);
        for (int k = 1; k <= 121; k++) begin
            clk_step(1'b1);
            hist_txd[k]  = txd;
            hist_busy[k] = busy;
            repeat (3) clk_step(1'b0);
        end
        cnt = 0;
        for (int k = 1; k <= 120; k++) if (hist_busy[k] === 1'b1) cnt++;
        check("b2b busy ticks", cnt, 120);
        check("b2b busy end", hist_busy[121], 0);
        check("b2b stop1 high", hist_txd[40], 1);
        check("b2b start2 low", hist_txd[41], 0);
        check("b2b stop2 high", hist_txd[80], 1);
        check("b2b start3 low", hist_txd[81], 0);
        rx_expect("b2b rx 0", 8'h48);
        rx_expect("b2b rx 1", 8'h69);
        rx_expect("b2b rx 2", 8'h0A);

        // FIFO full with tx_valid held
        d = 8'h01;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rb = bus.tx_ready;
            clk_step(1'b0);
            if (rb) begin
                d = d + 8'h01;
                bus.tx_data = d;
            end
        end
        check("full tx_ready", bus.tx_ready, 0);
        check("full level", level, 4);
        check("full pending byte", d, 8'h05);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            rb = bus.tx_ready;
            clk_step(cyc % 4 == 0);
            cyc++;
            if (bus.tx_valid && rb) bus.tx_valid = 1'b0;
            done = !bus.tx_valid && !busy && (level == 0);
        end
        check("full drain done", done, 1);
        for (int i = 1; i <= 5; i++) rx_expect($sformatf("full rx %0d", i), 8'(i));

        // Simultaneous push and pop from IDLE
        push(8'h3C);
        push(8'hC3);
        check("simul level before", level, 2);
        bus.tx_data  = 8'h7E;
        bus.tx_valid = 1'b1;
        clk_step(1'b1);
        bus.tx_valid = 1'b0;
        check("simul level after", level, 2);
        check("simul busy", busy, 1);
        wait_idle("simul drain", 3);
        rx_expect("simul rx 0", 8'h3C);
        rx_expect("simul rx 1", 8'hC3);
        rx_expect("simul rx 2", 8'h7E);

        // Reset during DATA bit 3 of 0xA5
        push(8'hA5);
        push(8'h11);
        push(8'h22);
        for (int k = 1; k <= 18; k++) begin
            clk_step(1'b1);
            clk_step(1'b0);
        end
        check("rst pre txd bit3", txd, 0);
        check("rst pre level", level, 2);
        #2;
        resetn = 1'b0;
        #1;
        check("rst async txd", txd, 1);
        check("rst async busy", busy, 0);
        check("rst async level", level, 0);
        check("rst async tx_ready", bus.tx_ready, 1);
        repeat (3) clk_step(1'b0);
        resetn = 1'b1;
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            clk_step(1'b1);
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("rst quiet after release", lows, 0);
        check("rst level after release", level, 0);
        check("rst rx silent", rx_q.size(), 0);

        // Loopback "OK\r\n" with tick held high
        push(8'h4F);
        push(8'h4B);
        push(8'h0D);
        push(8'h0A);
        check("loop full ready", bus.tx_ready, 0);
        wait_idle("loop drain", 0);
        rx_expect("loop rx O", 8'h4F);
        rx_expect("loop rx K", 8'h4B);
        rx_expect("loop rx CR", 8'h0D);
        rx_expect("loop rx LF", 8'h0A);
        check("loop framing errors", frame_err, 0);

        // Two stop bits
        bus2.tx_data  = 8'h00;
        bus2.tx_valid = 1'b1;
        clk_step(1'b0);
        bus2.tx_valid = 1'b0;
        cnt = 0;
        first_high = 0;
        end_k = 0;
        for (int k = 1; k <= 48; k++) begin
            clk_step(1'b1);
            clk_step(1'b0);
            if (busy2 === 1'b1) cnt++;
            if (first_high == 0 && txd2 === 1'b1 && busy2 === 1'b1) first_high = k;
            if (end_k == 0 && cnt > 0 && busy2 === 1'b0) end_k = k;
        end
        check("stop2 frame ticks", cnt, 44);
        check("stop2 stop ticks", end_k - first_high, 8);

        check("txd changes only on tick", glitch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
